// File: rtl/arbiter_pkg.sv
// Shared types and constants for the cache/memory arbiter.
// Line and beat geometry, plus the arbiter FSM state encoding.
package arbiter_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

    // True for the three states that own the memory port.
    function automatic logic is_burst(arb_state_t s);
        return (s == I_READ) || (s == D_READ) || (s == D_WRITE);
    endfunction

endpackage

// File: rtl/line_burst_buffer.sv
// Line <-> burst conversion: beat counter, read-line assembly
// register and combinational write-beat select.
module line_burst_buffer #(
    parameter int LINE_W = arbiter_pkg::LINE_W,
    parameter int BEAT_W = arbiter_pkg::BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              capture,
    input  logic              beat_ok,
    input  logic [BEAT_W-1:0] beat_rdata,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [BEAT_W-1:0] beat_wdata,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    localparam int NB = LINE_W / BEAT_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0]     beat_q;
    logic [LINE_W-1:0] line_q;
    logic              step;

    assign step      = active && beat_ok;
    assign last_beat = (beat_q == LAST);
    assign line      = line_q;

    // Beat counter: advances per transferred beat, wraps to 0 after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else if (step && last_beat) begin
            beat_q <= '0;
        end else if (step) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    // Assembly register: read beat n lands in slice n, beat 0 is the LSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (step && capture) begin
            line_q[int'(beat_q) * BEAT_W +: BEAT_W] <= beat_rdata;
        end
    end

    // Write-beat mux follows the counter so a held beat stays on the bus.
    always_comb begin
        beat_wdata = line_wdata[int'(beat_q) * BEAT_W +: BEAT_W];
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line misses onto one 4-beat burst port.
// dcache has fixed priority; grant is held until the line completes.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = arbiter_pkg::LINE_W,
    parameter int BEAT_W = arbiter_pkg::BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    import arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_state_t        grant_q;
    logic              in_burst;
    logic              is_read;
    logic              last_beat;
    logic [BEAT_W-1:0] beat_wdata;
    logic [LINE_W-1:0] line;

    assign in_burst = is_burst(state_q);
    assign is_read  = (state_q == I_READ) || (state_q == D_READ);

    line_burst_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .active     (in_burst),
        .capture    (is_read),
        .beat_ok    (mem_resp),
        .beat_rdata (mem_rdata),
        .line_wdata (d_wdata),
        .beat_wdata (beat_wdata),
        .line       (line),
        .last_beat  (last_beat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember which client owns the burst so DONE knows whom to answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= IDLE;
        end else if (state_q == IDLE) begin
            grant_q <= state_d;
        end
    end

    // Next state: dcache write beats dcache read beats icache read.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_write) begin
                    state_d = D_WRITE;
                end else if (d_read) begin
                    state_d = D_READ;
                end else if (i_read) begin
                    state_d = I_READ;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (mem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state; everything idles at zero.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        unique case (state_q)
            I_READ: begin
                mem_read    = 1'b1;
                mem_address = i_address & LINE_MASK;
            end
            D_READ: begin
                mem_read    = 1'b1;
                mem_address = d_address & LINE_MASK;
            end
            D_WRITE: begin
                mem_write   = 1'b1;
                mem_address = d_address & LINE_MASK;
                mem_wdata   = beat_wdata;
            end
            DONE: begin
                if (grant_q == I_READ) begin
                    i_resp  = 1'b1;
                    i_rdata = line;
                end else begin
                    d_resp  = 1'b1;
                    d_rdata = line;
                end
            end
            default: begin
            end
        endcase
    end

    // Flag a dcache that asks to read and write at once; the write is served.
    always @(posedge clk) begin
        if (!rst && state_q == IDLE) begin
            assert (!(d_read && d_write))
            else $warning("cache_mem_arbiter: d_read and d_write both high, write wins");
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table-driven bursts,
// scoreboarded completions and hand-written corner sequences.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    cache_mem_arbiter #(
        .ADDR_W (32),
        .LINE_W (256),
        .BEAT_W (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           is_wr;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] line;
        logic [31:0]  pat;
        int           lat;
    } vec_t;

    typedef struct {
        bit           is_d;
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_pass = 0;
    logic [31:0]  pat = 32'hFFFF_FFFF;
    logic [255:0] rd_line = '0;
    bit           force_resp = 1'b0;
    int           mb = 0;
    int           bcyc = 0;
    int           idle_cnt = 0;
    bit           had_burst = 1'b0;
    bit           busy;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    // Memory model and completion monitor, both on the falling edge.
    always @(negedge clk) begin
        busy = mem_read || mem_write;
        if (i_resp || d_resp) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b required 0 0",
                         i_resp, d_resp);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_client", {i_resp, d_resp}, e.is_d ? 2'b01 : 2'b10);
                if (!e.is_wr)
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.line);
                chk("latency", bcyc, e.lat);
            end
        end
        if (busy && !rst) begin
            if (bcyc == 0) begin
                if (had_burst) chk("idle_gap", idle_cnt >= 1, 1);
                if (sb.size() != 0)
                    chk("burst_start", {mem_address, mem_read, mem_write},
                        {sb[0].addr, !sb[0].is_wr, sb[0].is_wr});
            end
            had_burst = 1'b1;
            idle_cnt = 0;
            if (pat[bcyc % 32]) begin
                mem_resp = 1'b1;
                mem_rdata = rd_line[(mb % 4) * 64 +: 64];
                if (mem_write && sb.size() != 0)
                    chk("wbeat", mem_wdata, sb[0].line[(mb % 4) * 64 +: 64]);
                mb++;
            end else begin
                mem_resp = 1'b0;
                mem_rdata = 64'hBADB_ADBA_DBAD_BAD0;
            end
            bcyc++;
        end else begin
            mem_resp = force_resp;
            mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            mb = 0;
            bcyc = 0;
            idle_cnt++;
        end
    end

    task automatic wait_resp(input bit want_d);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (want_d ? d_resp : i_resp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL resp_timeout: got no %s_resp required one within 200 cycles",
                     want_d ? "d" : "i");
        end
    endtask

    task automatic push(input bit is_d, input bit is_wr, input logic [31:0] a,
                        input logic [255:0] l, input int lat);
        exp_t e;
        e.is_d = is_d;
        e.is_wr = is_wr;
        e.addr = a;
        e.line = l;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        pat = v.pat;
        if (v.is_wr) begin
            d_wdata = v.line;
            rd_line = {4{64'hBADC_0FFE_E0DD_F00D}};
        end else begin
            rd_line = v.line;
        end
        push(v.is_d, v.is_wr, v.exp_addr, v.line, v.lat);
        if (v.is_d) begin
            d_address = v.addr;
            d_read = !v.is_wr;
            d_write = v.is_wr;
        end else begin
            i_address = v.addr;
            i_read = 1'b1;
        end
        wait_resp(v.is_d);
        @(posedge clk); #1;
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        pat = 32'hFFFF_FFFF;
    endtask

    vec_t vecs[5];
    logic [255:0] la, lb, lw;

    initial begin
        vecs[0].is_d = 0; vecs[0].is_wr = 0;
        vecs[0].addr = 32'h0000_1234; vecs[0].exp_addr = 32'h0000_1220;
        vecs[0].line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vecs[0].pat = 32'hFFFF_FFFF; vecs[0].lat = 4;

        vecs[1].is_d = 1; vecs[1].is_wr = 1;
        vecs[1].addr = 32'h0000_0080; vecs[1].exp_addr = 32'h0000_0080;
        vecs[1].line = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                        64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
        vecs[1].pat = 32'hFFFF_FFFF; vecs[1].lat = 4;

        vecs[2].is_d = 1; vecs[2].is_wr = 0;
        vecs[2].addr = 32'hDEAD_BEEF; vecs[2].exp_addr = 32'hDEAD_BEE0;
        vecs[2].line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                        64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        vecs[2].pat = 32'h0000_0134; vecs[2].lat = 9;

        vecs[3].is_d = 0; vecs[3].is_wr = 0;
        vecs[3].addr = 32'hFFFF_FFE5; vecs[3].exp_addr = 32'hFFFF_FFE0;
        vecs[3].line = {64'h8000_0000_0000_0001, 64'h7777_7777_7777_7777,
                        64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3].pat = 32'h0000_00F0; vecs[3].lat = 8;

        vecs[4].is_d = 1; vecs[4].is_wr = 1;
        vecs[4].addr = 32'h1234_567F; vecs[4].exp_addr = 32'h1234_5660;
        vecs[4].line = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                        64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
        vecs[4].pat = 32'h0000_002D; vecs[4].lat = 6;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // same-cycle icache and dcache reads: dcache first
        la = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
              64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        lb = {64'hE3E3_1111_1111_1113, 64'hE2E2_1111_1111_1112,
              64'hE1E1_1111_1111_1111, 64'hE0E0_1111_1111_1110};
        @(posedge clk); #1;
        rd_line = la;
        push(1, 0, 32'h0000_2000, la, 4);
        push(0, 0, 32'h4000_0040, lb, 4);
        d_address = 32'h0000_2010;
        i_address = 32'h4000_0055;
        d_read = 1'b1;
        i_read = 1'b1;
        wait_resp(1'b1);
        rd_line = lb;
        @(posedge clk); #1;
        d_read = 1'b0;
        wait_resp(1'b0);
        @(posedge clk); #1;
        i_read = 1'b0;

        // stray mem_resp while idle must be ignored
        force_resp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_resp = 1'b0;
        run_vec(vecs[0]);

        // reset during beat 2 of a dcache read
        @(posedge clk); #1;
        rd_line = {4{64'h9999_9999_9999_9999}};
        d_address = 32'h0000_3000;
        d_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        d_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_d_resp", d_resp, 0);
        chk("abort_mem_address", mem_address, 0);
        repeat (4) @(posedge clk);
        had_burst = 1'b0;
        run_vec(vecs[3]);

        // conflicting dcache read and write: the write is performed
        lw = {64'h0BAD_0003_0000_0003, 64'h0BAD_0002_0000_0002,
              64'h0BAD_0001_0000_0001, 64'h0BAD_0000_0000_0000};
        @(posedge clk); #1;
        rd_line = {4{64'h7E7E_7E7E_7E7E_7E7E}};
        d_wdata = lw;
        d_address = 32'h0000_0C04;
        push(1, 1, 32'h0000_0C00, lw, 4);
        d_read = 1'b1;
        d_write = 1'b1;
        wait_resp(1'b1);
        @(posedge clk); #1;
        d_read = 1'b0;
        d_write = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates cache-line misses from the icache and dcache onto the single burst memory port at the top of `mp4`. The block sits directly upstream of the 64-bit × 4-beat burst memory and downstream of both caches' 256-bit line interfaces. It also performs the line-to-burst conversion: it serializes write lines and assembles read lines.

## Interface
- `ADDR_W`, default 32: address width.
- `LINE_W`, default 256: cache line width.
- `BEAT_W`, default 64: burst beat width. `LINE_W/BEAT_W` = 4 beats.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `i_read`  in  1  icache line read request, held until `i_resp`.
- `i_address`  in  `ADDR_W`  icache line address.
- `i_rdata`  out  `LINE_W`  read line, valid only while `i_resp`=1.
- `i_resp`  out  1  single-cycle completion pulse.
- `d_read` / `d_write`  in  1 each  dcache line read/write request, held until `d_resp`.
- `d_address`  in  `ADDR_W`  dcache line address.
- `d_wdata`  in  `LINE_W`  write line, stable while `d_write`=1.
- `d_rdata`  out  `LINE_W`  read line, valid only while `d_resp`=1.
- `d_resp`  out  1  single-cycle completion pulse.
- `mem_read` / `mem_write`  out  1 each  burst request, held until the 4th `mem_resp`.
- `mem_address`  out  `ADDR_W`  granted address with bits [4:0] forced to 0.
- `mem_wdata`  out  `BEAT_W`  current write beat.
- `mem_rdata`  in  `BEAT_W`  read beat, valid when `mem_resp`=1.
- `mem_resp`  in  1  one beat transferred this cycle.

## Operation
- FSM states: `IDLE`, `I_READ`, `D_READ`, `D_WRITE`, `DONE`.
- `IDLE` transitions, in priority order:
  - `d_write` → `D_WRITE`.
  - else `d_read` → `D_READ`.
  - else `i_read` → `I_READ`.
  - dcache has fixed priority. No starvation is possible because the pipeline stalls until both caches are satisfied.
- `d_read` and `d_write` both high is illegal. Write wins, and a simulation assertion fires.
- In `I_READ`, `D_READ` or `D_WRITE`:
  - `mem_read` or `mem_write` is high.
  - `mem_address` comes from the granted client, low 5 bits zeroed.
  - A 2-bit beat counter starts at 0 and advances only on `mem_resp`.
- Read beat n (on `mem_resp`) is stored to `line[64n+63:64n]`. Beat 0 is the least-significant beat.
- `mem_wdata` = `d_wdata[64*beat +: 64]`, selected combinationally from the beat counter.
- `mem_resp` with beat = 3 → `DONE`, counter cleared.
- `DONE`, one cycle:
  - The granted client's `*_resp` = 1 and `*_rdata` = the assembled line.
  - `mem_read` and `mem_write` are 0.
  - Next state is `IDLE`.
- Clients drop their request in the cycle after `resp`. `IDLE` samples requests only after `DONE`, so a completed request is never re-granted.
- The non-granted client's `resp` stays 0. Its request stays pending and is served from the next `IDLE`.

## Timing
- Reset values: state `IDLE`, beat counter 0, line buffer 0. All outputs are 0: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`.
- Outputs are Moore, decoded from state.
- Request seen in `IDLE` at cycle 0 → `mem_read`/`mem_write` high in cycle 1.
- The final `mem_resp` in cycle k → client `resp` in cycle k+1.
- Minimum round trip, with resp in cycles 1–4, is `resp` in cycle 5.
- There is at least one cycle with `mem_read`=`mem_write`=0 between consecutive bursts (`DONE` plus `IDLE`).
- Gaps in `mem_resp` are legal. The counter holds and the request stays asserted.
- `mem_resp` outside a burst state is ignored.
- `rst` mid-burst:
  - The next cycle is `IDLE`, with all outputs 0 and no `resp` issued.
  - Partial line data is discarded.
  - The next request starts from beat 0.

## Structure
- Shared package `arbiter_pkg` holds:
  - the state enum `arb_state_t`;
  - constants `LINE_W`, `BEAT_W`, `BEATS=4`, `OFFSET_BITS=5`.
- One sub-module, `line_burst_buffer`. It contains:
  - the beat counter;
  - the 256-bit assembly register;
  - the write-beat mux;
  - the `last_beat` flag.
  The FSM and grant logic live in the top module.

## Test plan
- `i_read`, `i_address`=0x0000_1234. Memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles. Expected: `mem_address`=0x0000_1220, `i_rdata`={0x4444…,0x3333…,0x2222…,0x1111…}, one-cycle `i_resp`, `d_resp`=0.
- `d_write`, `d_address`=0x80, `d_wdata` beat n = 0xA0+n replicated. Expected: `mem_wdata` sequence 0xA0…, 0xA1…, 0xA2…, 0xA3…; `mem_write` drops after the 4th resp; one `d_resp`.
- `i_read` and `d_read` raised in the same cycle. Expected: dcache burst completes first, then ≥1 idle cycle, then icache burst; each `resp` pulses exactly once.
- `mem_resp` gapped on cycles 3, 5, 6, 9. Expected: beats land in order and the line is correct; `resp` in cycle 10.
- `rst` pulsed during beat 2 of a `d_read`. Expected: next cycle `mem_read`=0, no `d_resp`; a subsequent `i_read` completes with correct data.
- `d_read` and `d_write` both high. Expected: write burst performed and assertion fires.
